snake_tile_renderer: RTL

SNAKE_TILE_RENDERER -- requirements
Module: snake_tile_renderer

---
 rtl/snake_tile_renderer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/snake_tile_renderer.sv
// snake_tile_renderer: scans snake segments once per line into tile bitmaps,
// then composites head/body colors over the background in a 3-stage pixel pipe.
module snake_tile_renderer #(
  parameter int MAX_SEGS = 100,
  parameter int COORD_W = 32,
  parameter int GRID_W = 10,
  parameter int GRID_H = 10,
  parameter int TILE_SIZE = 40,
  parameter int ORIGIN_X = 48,
  parameter int ORIGIN_Y = 48,
  parameter logic [11:0] BODY_COLOR = 12'h080,
  parameter logic [11:0] HEAD_COLOR = 12'h0F0,
  parameter int FLASH_FRAMES = 30
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [9:0]                   x,
  input  logic [9:0]                   y,
  input  logic                         active,
  input  logic                         line_start,
  input  logic                         frame_start,
  input  logic [MAX_SEGS*COORD_W-1:0]  seg_x,
  input  logic [MAX_SEGS*COORD_W-1:0]  seg_y,
  input  logic                         game_done,
  input  logic [11:0]                  bg_color,
  output logic [11:0]                  color_out,
  output logic                         scan_busy,
  output logic                         overrun
);
  localparam int IW = MAX_SEGS > 1 ? $clog2(MAX_SEGS) : 1;
  localparam int CW = $clog2(GRID_W) + 1;
  localparam int SW = TILE_SIZE > 1 ? $clog2(TILE_SIZE) : 1;
  localparam int FW = FLASH_FRAMES > 1 ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2;
  localparam logic [10:0] OX = 11'(ORIGIN_X);
  localparam logic [10:0] XE = 11'(ORIGIN_X + GRID_W * TILE_SIZE);
  localparam logic [10:0] OY = 11'(ORIGIN_Y);

  logic [1:0] state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [COORD_W-1:0] row_q, row_d;
  logic row_ok_q, row_ok_d;
  logic [GRID_W-1:0] sh_head_q, sh_head_d, sh_body_q, sh_body_d;
  logic [GRID_W-1:0] lv_head_q, lv_head_d, lv_body_q, lv_body_d;
  logic overrun_q, overrun_d;
  logic [CW-1:0] col_q, col_d;
  logic [SW-1:0] sub_q, sub_d;
  logic act1_q, act1_d, hd1_q, hd1_d, bd1_q, bd1_d;
  logic act2_q, act2_d, hd2_q, hd2_d, bd2_q, bd2_d;
  logic [11:0] color_q, color_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic vis_q, vis_d;

  logic [COORD_W-1:0] sx, sy;
  logic [10:0] nxt, row_calc;
  logic [GRID_W-1:0] seg_bit, col_bit;
  logic hit, at_ox, wrap, in_x, fwrap;

  assign sx = seg_x[idx_q*COORD_W +: COORD_W];
  assign sy = seg_y[idx_q*COORD_W +: COORD_W];
  assign nxt = {1'b0, y} + 11'd1;
  assign row_calc = (nxt - OY) / 11'(TILE_SIZE);
  assign hit = state_q == SCAN && row_ok_q && sx != '1 && sy != '1 && sy == row_q
               && sx < COORD_W'(GRID_W);
  assign seg_bit = GRID_W'(1) << sx;

  // A line_start overrides everything: abort an unfinished scan and restart for the new line.
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    row_d = row_q;
    row_ok_d = row_ok_q;
    sh_head_d = sh_head_q;
    sh_body_d = sh_body_q;
    lv_head_d = state_q == DONE ? sh_head_q : lv_head_q;
    lv_body_d = state_q == DONE ? sh_body_q : lv_body_q;
    overrun_d = overrun_q;
    if (state_q == DONE) state_d = IDLE;
    if (state_q == SCAN) begin
      idx_d = idx_q + 1'b1;
      state_d = idx_q == IW'(MAX_SEGS - 1) ? DONE : SCAN;
      sh_head_d = hit && idx_q == '0 ? sh_head_q | seg_bit : sh_head_q;
      sh_body_d = hit && idx_q != '0 ? sh_body_q | seg_bit : sh_body_q;
    end
    if (line_start) begin
      state_d = SCAN;
      idx_d = '0;
      row_d = COORD_W'(row_calc);
      row_ok_d = nxt >= OY && row_calc < 11'(GRID_H);
      sh_head_d = '0;
      sh_body_d = '0;
      overrun_d = overrun_q | (state_q == SCAN);
    end
  end

  // Column tracking relies on x stepping by one per pixel and passing ORIGIN_X each line.
  assign at_ox = {1'b0, x} == OX;
  assign wrap = sub_q == SW'(TILE_SIZE - 1);
  assign in_x = {1'b0, x} >= OX && {1'b0, x} < XE;
  assign col_bit = GRID_W'(1) << col_d;
  assign fwrap = fcnt_q == FW'(FLASH_FRAMES - 1);

  always_comb begin
    sub_d = at_ox || wrap ? '0 : sub_q + 1'b1;
    col_d = at_ox ? '0 : col_q + CW'(wrap);
    act1_d = active;
    hd1_d = in_x && |(lv_head_q & col_bit);
    bd1_d = in_x && |(lv_body_q & col_bit);
    act2_d = act1_q;
    hd2_d = hd1_q;
    bd2_d = bd1_q;
    color_d = !act2_q ? 12'h000 : hd2_q && vis_q ? HEAD_COLOR : bd2_q && vis_q ? BODY_COLOR : bg_color;
    fcnt_d = !game_done ? '0 : !frame_start ? fcnt_q : fwrap ? '0 : fcnt_q + 1'b1;
    vis_d = !game_done ? 1'b1 : frame_start && fwrap ? !vis_q : vis_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      row_q <= '0;
      row_ok_q <= 1'b0;
      sh_head_q <= '0;
      sh_body_q <= '0;
      lv_head_q <= '0;
      lv_body_q <= '0;
      overrun_q <= 1'b0;
      col_q <= '0;
      sub_q <= '0;
      act1_q <= 1'b0;
      hd1_q <= 1'b0;
      bd1_q <= 1'b0;
      act2_q <= 1'b0;
      hd2_q <= 1'b0;
      bd2_q <= 1'b0;
      color_q <= 12'h000;
      fcnt_q <= '0;
      vis_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      row_q <= row_d;
      row_ok_q <= row_ok_d;
      sh_head_q <= sh_head_d;
      sh_body_q <= sh_body_d;
      lv_head_q <= lv_head_d;
      lv_body_q <= lv_body_d;
      overrun_q <= overrun_d;
      col_q <= col_d;
      sub_q <= sub_d;
      act1_q <= act1_d;
      hd1_q <= hd1_d;
      bd1_q <= bd1_d;
      act2_q <= act2_d;
      hd2_q <= hd2_d;
      bd2_q <= bd2_d;
      color_q <= color_d;
      fcnt_q <= fcnt_d;
      vis_q <= vis_d;
    end
  end

  assign color_out = color_q;
  assign scan_busy = state_q == SCAN;
  assign overrun = overrun_q;
endmodule
